keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix-keypad input front end: the input-side counterpart of the LED display mux.
//  Drives one keypad column low at a time, reads the four row lines and debounces by
//  repeated scan samples. Emits a 4-bit key code with a one-cycle valid strobe, which
//  loads operand/opcode values into the datapath.
// PARAMETERS
//  SCAN_DIV       50000  clk50MHz cycles per scan tick (1 ms); column settle time, must be >=4
//  DEBOUNCE_TICKS 20     consecutive agreeing tick samples to accept a press or a release, >=1
// PORTS
//  clk50MHz   in   1  system clock, only clock in block
//  rst        in   1  synchronous, active-high reset
//  rows       in   4  keypad row lines, active-low (pulled up), asynchronous to clk50MHz
//  colsel     out  4  keypad column drive, active-low one-hot (4'b1110 = column 0)
//  key_code   out  4  {row[1:0], col[1:0]} of last accepted key; holds until next accept
//  key_valid  out  1  one-cycle strobe, key_code updated on the same cycle
//  key_held   out  1  high from accept until debounced release
// BEHAVIOUR
//  Reset: colsel=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, counters=0.
//  - rows pass through a 2-flop synchroniser (rows_s); logic uses only rows_s.
//  - Prescaler counts 0..SCAN_DIV-1 and wraps. tick=1 for one cycle at SCAN_DIV-1.
//  - All sampling and state decisions happen only on tick cycles.
//  - States:
//    SCAN: on tick, if any rows_s bit is low, capture cur_col and the lowest-index low row.
//      Set deb_cnt=1, go to DEBOUNCE, and keep the column. Otherwise advance the column
//      (3 wraps to 0).
//    DEBOUNCE: on tick, if rows_s[cap_row]==0, deb_cnt++; else go to SCAN and advance the
//      column, with no strobe. When a tick makes deb_cnt==DEBOUNCE_TICKS: register
//      key_code={cap_row,cap_col} and set key_valid=1 and key_held=1 on the next clock edge.
//      Go to HELD with deb_cnt=0. If DEBOUNCE_TICKS==1, accept on that same SCAN tick.
//    HELD: column frozen. Each tick with rows_s[cap_row]==1 increments deb_cnt; a tick
//      with it low clears deb_cnt. At deb_cnt==DEBOUNCE_TICKS: key_held=0, go to SCAN,
//      advance the column.
//  - key_valid is high for exactly one clk50MHz cycle per accepted press, never in HELD;
//    auto-repeat is not supported.
//  - Multiple keys:
//    - Within a column, the lowest row index wins.
//    - While in DEBOUNCE/HELD, other keys are ignored, including keys in the same column
//      on other rows.
//    - A key still down after release is re-detected when the scan reaches its column.
//  - Latency: a bounce-free press first sampled on tick T gives key_valid on the cycle
//    after tick T+DEBOUNCE_TICKS-1 (tick count), plus 2 synchroniser cycles before T.
//  - Reset mid-operation (any state): all outputs take reset values on the next edge.
//    A pending press produces no strobe.
//  - colsel always has exactly one bit low, including in reset.
// STRUCTURE
//  - keypad_pkg holds:
//    - state encoding SCAN/DEBOUNCE/HELD (2 bits)
//    - N_ROWS=4, N_COLS=4, KEY_W=4
//    - COLSEL_RESET=4'b1110
//  - Sub-module scan_prescaler (parameter DIV): counter plus one-cycle tick output,
//    reset to 0. Reused by other timed scanners.
//  - Remainder is flat: synchroniser, column register, FSM, debounce counter
//    ($clog2(DEBOUNCE_TICKS+1) bits), output registers.
// TESTING
//  Bench: SCAN_DIV=4, DEBOUNCE_TICKS=3. Keypad model: rows[r]=~|(press[r][c] & ~colsel[c]).
//  1. rst high 2 cycles mid-scan -> colsel=4'b1110, key_code=0, key_valid=0, key_held=0.
//  2. No keys for 20 cycles -> colsel steps 1110,1101,1011,0111,1110 every 4 clocks,
//     key_valid never asserted.
//  3. Press row2/col1 and hold -> one key_valid pulse with key_code=4'h9, key_held=1.
//     Then release -> key_held=0 after 3 ticks and colsel resumes at 4'b1011.
//  4. Row0/col3 low for 1 tick then released (bounce) -> no key_valid, scan resumes at col0.
//  5. Row0 and row3 of col2 pressed together -> single strobe with key_code=4'h2.
//     No second strobe while both are held.
//  6. rst asserted in DEBOUNCE and again in HELD -> no strobe, outputs and colsel at
//     reset values next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: geometry, state encoding,
// column-drive reset pattern and small decode helpers.
package keypad_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int KEY_W  = 4;

  // Column 0 driven low, all others released.
  localparam logic [N_COLS-1:0] COLSEL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Index of the lowest-numbered row that reads low (active-low rows).
  // Returns 0 when no row is low; callers qualify with an any-low test.
  function automatic logic [1:0] lowest_low_row(input logic [N_ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) begin
        idx = i[1:0];
      end
    end
    return idx;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [N_COLS-1:0] col_drive(input logic [1:0] col);
    logic [N_COLS-1:0] one;
    one = {{(N_COLS-1){1'b0}}, 1'b1};
    return ~(one << col);
  endfunction

endpackage

// File: rtl/keypad_scanner_prescaler.sv
// Free-running divider for timed scanners: counts 0..DIV-1 and raises tick
// for the single cycle in which the count sits at DIV-1.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk50MHz,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Wrap-around counter; the wrap cycle is the tick cycle.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end. Walks an active-low column drive, samples the
// synchronised row lines once per scan tick, debounces press and release by
// consecutive agreeing ticks, and reports each accepted key with a one-cycle
// strobe. While a key is being debounced or held the column stays frozen, so
// the frozen column doubles as the captured column.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic              clk50MHz,
  input  logic              rst,
  input  logic [N_ROWS-1:0] rows,
  output logic [N_COLS-1:0] colsel,
  output logic [KEY_W-1:0]  key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam bit SINGLE_TICK = (DEBOUNCE_TICKS == 1);

  logic tick;

  logic [N_ROWS-1:0] rows_meta_reg;
  logic [N_ROWS-1:0] rows_s_reg;

  scan_state_t state_reg, state_next;

  logic [1:0]        col_reg, col_next;
  logic [1:0]        cap_row_reg, cap_row_next;
  logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
  logic [N_COLS-1:0] colsel_reg, colsel_next;
  logic [KEY_W-1:0]  key_code_reg, key_code_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_held_reg, key_held_next;

  logic             any_low;
  logic [1:0]       scan_row;
  logic             cap_row_high;
  logic [DEB_W-1:0] deb_inc;
  logic             accept;
  logic             release_done;
  logic             advance;
  logic [1:0]       accept_row;

  scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .tick     (tick)
  );

  // Two-flop synchroniser for the asynchronous row lines; idle rows read high.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      rows_meta_reg <= '1;
      rows_s_reg    <= '1;
    end else begin
      rows_meta_reg <= rows;
      rows_s_reg    <= rows_meta_reg;
    end
  end

  // Tick-qualified decision terms shared by the FSM and datapath.
  assign any_low      = ~&rows_s_reg;
  assign scan_row     = lowest_low_row(rows_s_reg);
  assign cap_row_high = rows_s_reg[cap_row_reg];
  assign deb_inc      = deb_cnt_reg + DEB_ONE;
  assign accept       = tick &&
                        (((state_reg == SCAN) && any_low && SINGLE_TICK) ||
                         ((state_reg == DEBOUNCE) && !cap_row_high && (deb_inc == DEB_LAST)));
  assign release_done = tick && (state_reg == HELD) && cap_row_high && (deb_inc == DEB_LAST);
  assign advance      = tick &&
                        (((state_reg == SCAN) && !any_low) ||
                         ((state_reg == DEBOUNCE) && cap_row_high) ||
                         release_done);
  // A single-tick accept straight from SCAN has not yet latched its row.
  assign accept_row   = (state_reg == SCAN) ? scan_row : cap_row_reg;

  // FSM state register.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_reg <= SCAN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; transitions only happen on tick cycles.
  always_comb begin
    state_next = state_reg;
    if (tick) begin
      unique case (state_reg)
        SCAN: begin
          if (any_low) begin
            state_next = SINGLE_TICK ? HELD : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cap_row_high) begin
            state_next = SCAN;
          end else if (accept) begin
            state_next = HELD;
          end
        end
        HELD: begin
          if (release_done) begin
            state_next = SCAN;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // Output and datapath next values: column walk, row capture, debounce count, key outputs.
  always_comb begin
    col_next       = col_reg;
    cap_row_next   = cap_row_reg;
    deb_cnt_next   = deb_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    if (tick) begin
      unique case (state_reg)
        SCAN: begin
          if (any_low) begin
            cap_row_next = scan_row;
            deb_cnt_next = SINGLE_TICK ? '0 : DEB_ONE;
          end
        end
        DEBOUNCE: begin
          if (cap_row_high) begin
            deb_cnt_next = '0;
          end else if (accept) begin
            deb_cnt_next = '0;
          end else begin
            deb_cnt_next = deb_inc;
          end
        end
        HELD: begin
          if (!cap_row_high) begin
            deb_cnt_next = '0;
          end else if (release_done) begin
            deb_cnt_next = '0;
          end else begin
            deb_cnt_next = deb_inc;
          end
        end
        default: deb_cnt_next = '0;
      endcase
    end

    if (advance) begin
      col_next = col_reg + 2'd1;
    end

    if (accept) begin
      key_code_next  = {accept_row, col_reg};
      key_valid_next = 1'b1;
      key_held_next  = 1'b1;
    end

    if (release_done) begin
      key_held_next = 1'b0;
    end

    colsel_next = col_drive(col_next);
  end

  // Datapath and output registers; colsel is registered so the keypad sees a clean drive.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      col_reg       <= 2'd0;
      cap_row_reg   <= 2'd0;
      deb_cnt_reg   <= '0;
      colsel_reg    <= COLSEL_RESET;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      col_reg       <= col_next;
      cap_row_reg   <= cap_row_next;
      deb_cnt_reg   <= deb_cnt_next;
      colsel_reg    <= colsel_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  assign colsel    = colsel_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a scoreboard: stimulus pushes the
// expected key code of every press that should be accepted, and a monitor pops
// and compares on each key_valid strobe. Any strobe with nothing queued fails.
module tb_keypad_scanner;

  logic       clk50MHz;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] colsel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0] press [4];
  logic [3:0] exp_q [$];
  logic [3:0] col_seq [4];

  int n_checks;
  int n_fail;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk50MHz  (clk50MHz),
    .rst       (rst),
    .rows      (rows),
    .colsel    (colsel),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk50MHz = 1'b0;
  always #5 clk50MHz = ~clk50MHz;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = '1;
    for (int r = 0; r < 4; r++) begin
      rows[r] = ~|(press[r] & ~colsel);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Wait (bounded) at negedges until key_held reaches the wanted level.
  task automatic wait_held(input logic want, input int max_cycles, input string name);
    int c;
    c = 0;
    while (key_held !== want && c < max_cycles) begin
      @(negedge clk50MHz);
      c++;
    end
    check(name, key_held, want);
  endtask

  // Wait (bounded) at negedges until colsel shows the wanted pattern.
  task automatic wait_col(input logic [3:0] want, input int max_cycles, input string name);
    int c;
    c = 0;
    while (colsel !== want && c < max_cycles) begin
      @(negedge clk50MHz);
      c++;
    end
    check(name, colsel, want);
  endtask

  task automatic clear_press();
    for (int r = 0; r < 4; r++) begin
      press[r] = 4'b0000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_colsel"}, colsel, 4'b1110);
    check({tag, "_key_code"}, key_code, 4'h0);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_key_held"}, key_held, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk50MHz);
      if (key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", key_valid, 1'b0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("strobe_code", key_code, e);
          check("strobe_held", key_held, 1'b1);
          $display("strobe: key_code=%h expected=%h", key_code, e);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_checks = 0;
    n_fail   = 0;
    col_seq[0] = 4'b1110;
    col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111;
    clear_press();
    rst = 1'b1;
    repeat (2) @(negedge clk50MHz);
    rst = 1'b0;

    // 1: reset mid-scan
    repeat (7) @(negedge clk50MHz);
    rst = 1'b1;
    repeat (2) @(negedge clk50MHz);
    check_reset_outputs("reset_mid_scan");
    rst = 1'b0;
    $display("txn 1: mid-scan reset, colsel=%b", colsel);

    // 2: idle scanning, column changes every SCAN_DIV clocks
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk50MHz);
      check($sformatf("idle_colsel_%0d", n), colsel, col_seq[(n / 4) % 4]);
    end
    $display("txn 2: idle scan complete, colsel=%b", colsel);

    // 3: press row2/col1, hold, release
    exp_q.push_back(4'h9);
    press[2][1] = 1'b1;
    wait_held(1'b1, 200, "press_r2c1_held");
    check("press_r2c1_code", key_code, 4'h9);
    repeat (40) @(negedge clk50MHz);
    check("hold_r2c1_held", key_held, 1'b1);
    press[2][1] = 1'b0;
    c = 0;
    while (key_held === 1'b1 && c < 100) begin
      @(negedge clk50MHz);
      c++;
    end
    check_range("release_latency", c, 11, 14);
    check("release_colsel", colsel, 4'b1011);
    $display("txn 3: key 9 pressed and released, release after %0d cycles", c);

    // 4: one-tick bounce on row0/col3
    wait_col(4'b0111, 100, "bounce_reach_col3");
    press[0][3] = 1'b1;
    repeat (4) @(negedge clk50MHz);
    press[0][3] = 1'b0;
    @(negedge clk50MHz);
    check("bounce_col_frozen", colsel, 4'b0111);
    repeat (3) @(negedge clk50MHz);
    check("bounce_resume_col0", colsel, 4'b1110);
    repeat (30) @(negedge clk50MHz);
    check("bounce_no_held", key_held, 1'b0);
    $display("txn 4: bounce rejected, colsel=%b", colsel);

    // 5: row0 and row3 of col2 together
    exp_q.push_back(4'h2);
    press[0][2] = 1'b1;
    press[3][2] = 1'b1;
    wait_held(1'b1, 200, "multi_held");
    check("multi_code", key_code, 4'h2);
    repeat (60) @(negedge clk50MHz);
    check("multi_still_held", key_held, 1'b1);
    clear_press();
    wait_held(1'b0, 100, "multi_release");
    $display("txn 5: two keys in col2, key_code=%h", key_code);

    // 6a: reset while debouncing
    wait_col(4'b1101, 100, "deb_reach_col1");
    press[1][1] = 1'b1;
    repeat (5) @(negedge clk50MHz);
    check("deb_col_frozen", colsel, 4'b1101);
    rst = 1'b1;
    clear_press();
    @(negedge clk50MHz);
    check_reset_outputs("reset_in_debounce");
    rst = 1'b0;
    repeat (40) @(negedge clk50MHz);
    check("after_deb_reset_no_held", key_held, 1'b0);
    $display("txn 6a: reset during debounce, colsel=%b", colsel);

    // 6b: reset while held
    exp_q.push_back(4'hC);
    press[3][0] = 1'b1;
    wait_held(1'b1, 200, "held_before_reset");
    check("held_before_reset_code", key_code, 4'hC);
    rst = 1'b1;
    clear_press();
    @(negedge clk50MHz);
    check_reset_outputs("reset_in_held");
    rst = 1'b0;
    repeat (40) @(negedge clk50MHz);
    $display("txn 6b: reset during held, colsel=%b", colsel);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
